// File: rtl/winewhite_bnn1_bnnrom_esx.sv
// Sequential BNN classifier: one hidden neuron per cycle, then one class score per cycle,
// argmax latched into prediction once per reset. Weights come from parameter ROMs.
//
// state | meaning
// HID   | evaluate hidden neuron cnt against W1 row cnt
// CLS   | score class cnt against W2 row cnt, track running argmax
// DONE  | prediction held until the next reset
module winewhite_bnn1_bnnrom_esx #(
  parameter int FEAT_CNT   = 11,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 7,
  parameter int IN_W       = FEAT_CNT * FEAT_BITS,
  parameter int THRESH     = (IN_W + 1) / 2,
  parameter logic [HIDDEN_CNT*IN_W-1:0]      W1_ROM = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_ROM = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_W-1:0]              features,
  output logic [$clog2(CLASS_CNT)-1:0] prediction
);

  localparam int CNT_MAX  = (HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int MATCH_W  = $clog2(IN_W + 1);
  localparam int SUM_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int IDX_W    = $clog2(CLASS_CNT);
  localparam logic [CNT_W-1:0] HID_LAST = CNT_W'(HIDDEN_CNT - 1);
  localparam logic [CNT_W-1:0] CLS_LAST = CNT_W'(CLASS_CNT - 1);

  typedef enum logic [1:0] {HID, CLS, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [HIDDEN_CNT-1:0] hidden, hidden_nxt;
  logic [SUM_BITS-1:0]   best_score, best_score_nxt;
  logic [IDX_W-1:0]      best_idx, best_idx_nxt, prediction_nxt;

  logic [IN_W-1:0]       w1_row, xnor1;
  logic [HIDDEN_CNT-1:0] w2_row, xnor2;
  logic [MATCH_W-1:0]    match;
  logic [SUM_BITS-1:0]   score;
  logic                  fire;
  logic                  take;
  logic [IDX_W-1:0]      cand_idx;

  // Row reads are guarded so the counter range of the other phase never indexes past a ROM.
  always_comb begin
    w1_row = '0;
    if (int'(cnt) < HIDDEN_CNT) w1_row = W1_ROM[int'(cnt)*IN_W +: IN_W];
    xnor1 = ~(features ^ w1_row);
    match = '0;
    for (int i = 0; i < IN_W; i++) match = match + MATCH_W'(xnor1[i]);
    fire = (int'(match) >= THRESH);
  end

  always_comb begin
    w2_row = '0;
    if (int'(cnt) < CLASS_CNT) w2_row = W2_ROM[int'(cnt)*HIDDEN_CNT +: HIDDEN_CNT];
    xnor2 = ~(hidden ^ w2_row);
    score = '0;
    for (int i = 0; i < HIDDEN_CNT; i++) score = score + SUM_BITS'(xnor2[i]);
    take     = (cnt == '0) || (score > best_score);
    cand_idx = take ? IDX_W'(cnt) : best_idx;
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hidden_nxt     = hidden;
    best_score_nxt = best_score;
    best_idx_nxt   = best_idx;
    prediction_nxt = prediction;
    case (state)
      HID: begin
        for (int j = 0; j < HIDDEN_CNT; j++)
          if (int'(cnt) == j) hidden_nxt[j] = fire;
        if (cnt == HID_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CLS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CLS: begin
        if (take) begin
          best_score_nxt = score;
          best_idx_nxt   = IDX_W'(cnt);
        end
        if (cnt == CLS_LAST) begin
          prediction_nxt = cand_idx;
          state_nxt      = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HID;
      cnt        <= '0;
      hidden     <= '0;
      best_score <= '0;
      best_idx   <= '0;
      prediction <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hidden     <= hidden_nxt;
      best_score <= best_score_nxt;
      best_idx   <= best_idx_nxt;
      prediction <= prediction_nxt;
    end
  end

endmodule

// File: tb/tb_winewhite_bnn1_bnnrom_esx.sv
// Directed bench: several ROM configurations instantiated side by side, shared clock and reset.
module tb_winewhite_bnn1_bnnrom_esx;

  localparam int IN_W = 44;
  localparam logic [IN_W-1:0] ONES  = {IN_W{1'b1}};
  localparam logic [IN_W-1:0] Z22   = 44'h000003FFFFF;
  localparam logic [IN_W-1:0] Z21   = 44'h000007FFFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [IN_W-1:0] fa, fb, fc, fd, fe, ff;
  logic [2:0] pa, pb, pc, pd, pe, pf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  winewhite_bnn1_bnnrom_esx #(.W2_ROM({120'h0, {40{1'b1}}, 120'h0}))
    u_a (.clk(clk), .rst(rst), .features(fa), .prediction(pa));
  winewhite_bnn1_bnnrom_esx #(.W2_ROM({{40{1'b1}}, 40'h0, {200{1'b1}}}))
    u_b (.clk(clk), .rst(rst), .features(fb), .prediction(pb));
  winewhite_bnn1_bnnrom_esx #(.W2_ROM(280'h0))
    u_c (.clk(clk), .rst(rst), .features(fc), .prediction(pc));
  winewhite_bnn1_bnnrom_esx #(.W2_ROM({{40{1'b1}}, 120'h0, {40{1'b1}}, 80'h0}))
    u_d (.clk(clk), .rst(rst), .features(fd), .prediction(pd));
  winewhite_bnn1_bnnrom_esx #(.W2_ROM({200'h0, 40'h1, 40'h0}))
    u_e (.clk(clk), .rst(rst), .features(fe), .prediction(pe));
  // Hidden rows 0..19 all-zero weights, rows 20..39 all-one weights.
  winewhite_bnn1_bnnrom_esx #(
    .W1_ROM({{880{1'b1}}, {880{1'b0}}}),
    .W2_ROM({40'hFFFFF00000, 40'h0, 40'h00000FFFFF, 160'h0}))
    u_f (.clk(clk), .rst(rst), .features(ff), .prediction(pf));

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, pa, 3'd0);
    check({tag, "_b"}, pb, 3'd0);
    check({tag, "_d"}, pd, 3'd0);
    check({tag, "_e"}, pe, 3'd0);
    check({tag, "_f"}, pf, 3'd0);
  endtask

  initial begin
    fa = '0; fb = ONES; fc = '0; fd = '0; fe = Z22; ff = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");

    // Run 1: release and check latency boundary.
    @(negedge clk) rst = 1'b1;
    repeat (46) @(posedge clk);
    #1 check_all_zero("cyc46");
    @(posedge clk);
    #1;
    check("cyc47_a_row3",      pa, 3'd3);
    check("cyc47_b_row5",      pb, 3'd5);
    check("cyc47_c_tie0",      pc, 3'd0);
    check("cyc47_d_tie26",     pd, 3'd2);
    check("cyc47_e_thr22",     pe, 3'd1);
    check("cyc47_f_w1split",   pf, 3'd4);
    repeat (13) @(posedge clk);
    #1 check("cyc60_a_hold", pa, 3'd3);

    // Features change after completion: no effect.
    fa = ONES; ff = ONES; fe = '0; fd = ONES;
    repeat (5) @(posedge clk);
    #1;
    check("done_feat_a", pa, 3'd3);
    check("done_feat_f", pf, 3'd4);
    check("done_feat_d", pd, 3'd2);

    // Asynchronous clear away from any clock edge.
    #2 rst = 1'b0;
    #1;
    check("async_clr_a", pa, 3'd0);
    check("async_clr_f", pf, 3'd0);
    check("async_clr_b", pb, 3'd0);

    // Run 2: reset pulled mid-computation at cycle 20, then full restart.
    fa = '0; fb = ONES; fd = '0; fe = Z21; ff = ONES;
    @(negedge clk) rst = 1'b1;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("mid_clr_a", pa, 3'd0);
    @(negedge clk) rst = 1'b1;
    repeat (46) @(posedge clk);
    #1 check_all_zero("r2_cyc46");
    @(posedge clk);
    #1;
    check("r2_cyc47_a",        pa, 3'd3);
    check("r2_cyc47_b",        pb, 3'd5);
    check("r2_cyc47_e_thr21",  pe, 3'd0);
    check("r2_cyc47_f_ones",   pf, 3'd6);
    repeat (4) @(posedge clk);
    #1 check("r2_hold_f", pf, 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
